// File: rtl/uart_cmd_tx.sv
// uart_cmd_tx -- queued UART command transmitter.
// Command words are pushed into a small FIFO and sent back-to-back as
// start / DATA_BITS data bits (LSB first) / stop frames, with an optional
// idle-high gap of GAP_CYCLES after each stop bit.
// Build option: define UART_CMD_PARITY_EN to insert an even-parity bit
// between the last data bit and the stop bit.
module uart_cmd_tx #(
    parameter int DATA_BITS  = 8,
    parameter int BAUD_DIV   = 2604,
    parameter int FIFO_DEPTH = 4,
    parameter int GAP_CYCLES = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 wr_en,
    input  logic [DATA_BITS-1:0] wr_data,
    output logic                 TX,
    output logic                 full,
    output logic                 empty,
    output logic                 busy,
    output logic                 tx_done,
    output logic                 ovfl
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int BAUD_W = $clog2(BAUD_DIV);
    localparam int BIT_W  = $clog2(DATA_BITS);
    localparam int GAP_W  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_DIV - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);

`ifdef UART_CMD_PARITY_EN
    typedef enum logic [2:0] { S_IDLE, S_START, S_DATA, S_PAR, S_STOP, S_GAP } state_t;
`else
    typedef enum logic [2:0] { S_IDLE, S_START, S_DATA, S_STOP, S_GAP } state_t;
`endif

    // FIFO storage and bookkeeping
    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]     count_q, count_d;
    logic                 full_q, empty_q, ovfl_q;
    logic                 push, pop;

    // Transmitter state
    state_t               state_q;
    logic [BAUD_W-1:0]    baud_q;
    logic [BIT_W-1:0]     bit_q;
    logic [GAP_W-1:0]     gap_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 tx_q, tx_done_q, busy_q;
`ifdef UART_CMD_PARITY_EN
    logic                 parity_q;
`endif

    // Push/pop handshake and next FIFO occupancy
    always_comb begin
        // NOTE: combinational logic uses blocking '=' and gives every output a
        // default first, so no path leaves a value held and no latch is inferred.
        pop     = (state_q == S_IDLE) && !empty_q;
        push    = wr_en && (!full_q || pop);
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
    end

    // FIFO pointers, registered flags and sticky overflow
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: clocked state uses non-blocking '<=' so every flop samples the
        // pre-edge values regardless of statement order.
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            ovfl_q   <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
            full_q  <= (count_d == CNT_FULL);
            empty_q <= (count_d == '0);
            if (wr_en && !push) ovfl_q <= 1'b1;
        end
    end

    // FIFO data array
    always_ff @(posedge clk) begin
        // NOTE: the storage array has no reset; empty_q guards every read, so
        // stale contents are never observed and the array maps to plain RAM.
        if (push) mem_q[wr_ptr_q] <= wr_data;
    end

    // Frame sequencer; TX, tx_done and busy are driven straight from flops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            baud_q    <= '0;
            bit_q     <= '0;
            gap_q     <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
            tx_done_q <= 1'b0;
            busy_q    <= 1'b0;
`ifdef UART_CMD_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            tx_done_q <= 1'b0;
            baud_q    <= baud_q + 1'b1;
            unique case (state_q)
                S_IDLE: begin
                    tx_q   <= 1'b1;
                    baud_q <= '0;
                    if (pop) begin
                        shift_q  <= mem_q[rd_ptr_q];
`ifdef UART_CMD_PARITY_EN
                        parity_q <= ^mem_q[rd_ptr_q];
`endif
                        bit_q    <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= S_START;
                    end
                end
                S_START: begin
                    tx_q <= 1'b0;
                    if (baud_q == BAUD_LAST) begin
                        baud_q  <= '0;
                        state_q <= S_DATA;
                    end
                end
                S_DATA: begin
                    tx_q <= shift_q[0];
                    if (baud_q == BAUD_LAST) begin
                        baud_q  <= '0;
                        shift_q <= shift_q >> 1;
                        bit_q   <= bit_q + 1'b1;
                        if (bit_q == BIT_LAST) begin
`ifdef UART_CMD_PARITY_EN
                            state_q <= S_PAR;
`else
                            state_q <= S_STOP;
`endif
                        end
                    end
                end
`ifdef UART_CMD_PARITY_EN
                S_PAR: begin
                    tx_q <= parity_q;
                    if (baud_q == BAUD_LAST) begin
                        baud_q  <= '0;
                        state_q <= S_STOP;
                    end
                end
`endif
                S_STOP: begin
                    tx_q <= 1'b1;
                    if (baud_q == BAUD_LAST) begin
                        baud_q    <= '0;
                        tx_done_q <= 1'b1;
                        if (GAP_CYCLES > 0) begin
                            gap_q   <= '0;
                            state_q <= S_GAP;
                        end else begin
                            busy_q  <= 1'b0;
                            state_q <= S_IDLE;
                        end
                    end
                end
                S_GAP: begin
                    tx_q  <= 1'b1;
                    gap_q <= gap_q + 1'b1;
                    if (gap_q == GAP_LAST) begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    tx_q    <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign TX      = tx_q;
    assign full    = full_q;
    assign empty   = empty_q;
    assign busy    = busy_q;
    assign tx_done = tx_done_q;
    assign ovfl    = ovfl_q;

endmodule
